// File: rtl/lpc_capture_pkg.sv
// Shared types and constants for the LPC capture sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lpc_capture_pkg;

  localparam logic [7:0] MARKER = 8'hA5;
  localparam int         REC_W  = 72;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_HDR,
    ST_ADDR,
    ST_DATA
  } state_e;

  // Field order matches the frame order: header nibbles, then address, then data.
  typedef struct packed {
    logic [3:0]  ctdir;
    logic [3:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } rec_t;

  // Number of data bytes carried in a frame; unsupported sizes carry none.
  function automatic logic [2:0] data_bytes(input logic [3:0] size);
    case (size)
      4'd1:    return 3'd1;
      4'd2:    return 3'd2;
      4'd4:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/lpc_record_fifo.sv
// Record FIFO holding captured LPC transactions awaiting serialisation.
// Latency: a record pushed on edge E is visible at head_dat after E.
// Backpressure: push while full is ignored unless a pop happens on the same edge.
// Ports: clk/rst (async active-high); push/push_dat write side; pop read side;
//        full/empty status; head_dat is the oldest record, read straight from storage flops.
module lpc_record_fifo
  import lpc_capture_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [REC_W-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [REC_W-1:0] head_dat
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [REC_W-1:0] mem_q [DEPTH];
  logic [REC_W-1:0] mem_d [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    pop_ok  = pop && !empty;
    // When full, the slot being written is the one popped on this same edge.
    push_ok = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      mem_d[wr_ptr_q[AW-1:0]] = push_dat;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: contents are only read behind a valid pointer pair.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/lpc_capture_sched.sv
// Filters decoded LPC cycles, queues them and serialises each as a framed byte stream.
// Latency: record pushed at edge E into an idle, empty block drives the marker byte after E+1.
// Backpressure: tx_data/tx_valid hold until tx_ready; records arriving with the queue full are dropped and counted.
// Ports: lpc_clock/lpc_reset (async active-high); in_* decoded transaction with in_valid strobe;
//        filter_mask per-cycle-type accept; tx_data/tx_valid/tx_ready byte stream;
//        overflow_count saturating drop count; busy = record queued or in flight.
module lpc_capture_sched
  import lpc_capture_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        lpc_clock,
  input  logic        lpc_reset,
  input  logic        in_valid,
  input  logic [3:0]  in_cyctype_dir,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_data_size,
  input  logic [15:0] filter_mask,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  overflow_count,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  rec_t        rec_q, rec_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  ovf_q, ovf_d;

  rec_t        in_rec;
  rec_t        fifo_head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        accept;
  logic        pop;
  logic        hs;
  logic        last;
  logic [2:0]  n;

  lpc_record_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (lpc_clock),
    .rst      (lpc_reset),
    .push     (accept),
    .push_dat (in_rec),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_dat (fifo_head)
  );

  always_comb begin
    in_rec = {in_cyctype_dir, in_data_size, in_addr, in_data};
    accept = in_valid && filter_mask[in_cyctype_dir];
    hs     = tx_valid_q && tx_ready;
    n      = data_bytes(rec_q.size);

    state_d = state_q;
    idx_d   = idx_q;
    rec_d   = rec_q;
    pop     = 1'b0;
    last    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_MARK;
          rec_d   = fifo_head;
          pop     = 1'b1;
        end
      end
      ST_MARK: begin
        if (hs) state_d = ST_HDR;
      end
      ST_HDR: begin
        if (hs) begin
          state_d = ST_ADDR;
          idx_d   = 2'd3;
        end
      end
      ST_ADDR: begin
        if (hs) begin
          if (idx_q != 2'd0) begin
            idx_d = idx_q - 2'd1;
          end else if (n == 3'd0) begin
            last = 1'b1;
          end else begin
            state_d = ST_DATA;
            idx_d   = 2'(n - 3'd1);
          end
        end
      end
      ST_DATA: begin
        if (hs) begin
          if (idx_q != 2'd0) idx_d = idx_q - 2'd1;
          else               last  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Chain straight into the next record so back-to-back frames have no bubble.
    if (last) begin
      if (!fifo_empty) begin
        state_d = ST_MARK;
        rec_d   = fifo_head;
        pop     = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end

    // Output byte is selected from the next state so it is registered and
    // naturally holds while no handshake advances the state.
    tx_valid_d = (state_d != ST_IDLE);
    tx_data_d  = tx_data_q;
    case (state_d)
      ST_MARK: tx_data_d = MARKER;
      ST_HDR:  tx_data_d = {rec_d.ctdir, rec_d.size};
      ST_ADDR: tx_data_d = rec_d.addr[{idx_d, 3'b000} +: 8];
      ST_DATA: tx_data_d = rec_d.data[{idx_d, 3'b000} +: 8];
      default: tx_data_d = tx_data_q;
    endcase

    ovf_d = ovf_q;
    if (accept && fifo_full && !pop && (ovf_q != 8'hFF)) begin
      ovf_d = ovf_q + 8'd1;
    end
  end

  always_ff @(posedge lpc_clock or posedge lpc_reset) begin
    if (lpc_reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= 2'd0;
      rec_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      ovf_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rec_q      <= rec_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign tx_data        = tx_data_q;
  assign tx_valid       = tx_valid_q;
  assign overflow_count = ovf_q;
  assign busy           = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_lpc_capture_sched.sv
// Self-checking bench for lpc_capture_sched: vector table, corner sequences, random stream.
// Latency: n/a.
// Backpressure: tx_ready driven by the bench.
module tb_lpc_capture_sched;

  localparam int DEPTH = 4;

  logic        lpc_clock;
  logic        lpc_reset;
  logic        in_valid;
  logic [3:0]  in_cyctype_dir;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [3:0]  in_data_size;
  logic [15:0] filter_mask;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  overflow_count;
  logic        busy;

  lpc_capture_sched #(
    .DEPTH (DEPTH)
  ) dut (
    .lpc_clock      (lpc_clock),
    .lpc_reset      (lpc_reset),
    .in_valid       (in_valid),
    .in_cyctype_dir (in_cyctype_dir),
    .in_addr        (in_addr),
    .in_data        (in_data),
    .in_data_size   (in_data_size),
    .filter_mask    (filter_mask),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .overflow_count (overflow_count),
    .busy           (busy)
  );

  initial begin
    lpc_clock = 1'b0;
    forever #5 lpc_clock = ~lpc_clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  // Reference frame builder straight from the frame definition.
  function automatic void push_frame(input logic [3:0] ctdir, input logic [3:0] size,
                                     input logic [31:0] addr, input logic [31:0] data);
    int nb;
    exp_q.push_back(8'hA5);
    exp_q.push_back({ctdir, size});
    for (int i = 3; i >= 0; i--) exp_q.push_back(8'(addr >> (8 * i)));
    nb = (size == 4'd1 || size == 4'd2 || size == 4'd4) ? int'(size) : 0;
    for (int i = nb - 1; i >= 0; i--) exp_q.push_back(8'(data >> (8 * i)));
  endfunction

  task automatic cmp_stream(input string name);
    int nmin;
    chk({name, " length"}, got_q.size(), exp_q.size());
    nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) begin
      chk($sformatf("%s byte %0d", name, i), got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic step();
    @(posedge lpc_clock);
    #1;
  endtask

  task automatic strobe(input logic [3:0] ctdir, input logic [3:0] size,
                        input logic [31:0] addr, input logic [31:0] data);
    in_cyctype_dir = ctdir;
    in_data_size   = size;
    in_addr        = addr;
    in_data        = data;
    in_valid       = 1'b1;
    step();
    in_valid       = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (!busy && !tx_valid && got_q.size() >= exp_q.size()) break;
      step();
    end
  endtask

  // Stream monitor: collects accepted bytes and checks bytes hold under stall.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_dat   = 8'h00;
  always @(negedge lpc_clock) begin
    if (lpc_reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall tx_valid hold", tx_valid, 1'b1);
        chk("stall tx_data hold", tx_data, prev_dat);
      end
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      prev_stall = tx_valid && !tx_ready;
      prev_dat   = tx_data;
    end
  end

  typedef struct {
    logic [3:0]  ctdir;
    logic [3:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic [15:0] mask;
    int          exp_len;
    logic [7:0]  exp_hdr;
    logic [7:0]  exp_last;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cnt;
    int ends[$];
    logic [3:0]  r_ct;
    logic [3:0]  r_sz;
    logic [31:0] r_ad;
    logic [31:0] r_da;
    logic [15:0] r_mk;

    vecs[0] = '{4'h4, 4'h2, 32'hAFFE7FE5, 32'h0000DF6C, 16'h0010,  8, 8'h42, 8'h6C};
    vecs[1] = '{4'h4, 4'h2, 32'hAFFE7FE5, 32'h0000DF6C, 16'hFFEF,  0, 8'h00, 8'h00};
    vecs[2] = '{4'h4, 4'h1, 32'h12345678, 32'h0000003C, 16'h0010,  7, 8'h41, 8'h3C};
    vecs[3] = '{4'h7, 4'h3, 32'hCAFEBABE, 32'hDEADBEEF, 16'h0080,  6, 8'h73, 8'hBE};
    vecs[4] = '{4'hF, 4'h4, 32'h01020304, 32'h11223344, 16'h8000, 10, 8'hF4, 8'h44};
    vecs[5] = '{4'h3, 4'h0, 32'hA0B0C0D0, 32'hFFFFFFFF, 16'h0008,  6, 8'h30, 8'hD0};

    lpc_reset      = 1'b1;
    in_valid       = 1'b0;
    in_cyctype_dir = 4'h0;
    in_addr        = 32'h0;
    in_data        = 32'h0;
    in_data_size   = 4'h0;
    filter_mask    = 16'h0000;
    tx_ready       = 1'b1;

    // Reset state
    step();
    step();
    chk("reset tx_valid", tx_valid, 1'b0);
    chk("reset tx_data", tx_data, 8'h00);
    chk("reset overflow_count", overflow_count, 8'h00);
    chk("reset busy", busy, 1'b0);
    lpc_reset = 1'b0;
    step();

    // Vector table: one frame per entry with tx_ready high.
    for (int v = 0; v < 6; v++) begin
      filter_mask = vecs[v].mask;
      got_q.delete();
      exp_q.delete();
      if (vecs[v].mask[vecs[v].ctdir]) push_frame(vecs[v].ctdir, vecs[v].size, vecs[v].addr, vecs[v].data);
      strobe(vecs[v].ctdir, vecs[v].size, vecs[v].addr, vecs[v].data);
      chk($sformatf("vec%0d busy after strobe", v), busy, vecs[v].mask[vecs[v].ctdir]);
      wait_idle(40);
      chk($sformatf("vec%0d frame length", v), got_q.size(), vecs[v].exp_len);
      if (vecs[v].exp_len > 0 && got_q.size() > 1) begin
        chk($sformatf("vec%0d header", v), got_q[1], vecs[v].exp_hdr);
        chk($sformatf("vec%0d last byte", v), got_q[got_q.size() - 1], vecs[v].exp_last);
      end
      cmp_stream($sformatf("vec%0d stream", v));
      chk($sformatf("vec%0d busy end", v), busy, 1'b0);
      chk($sformatf("vec%0d overflow", v), overflow_count, 8'h00);
    end

    // Latency and exact tx_valid window for the reference record.
    filter_mask = 16'h0010;
    tx_ready    = 1'b1;
    got_q.delete();
    exp_q.delete();
    exp_q = '{8'hA5, 8'h42, 8'hAF, 8'hFE, 8'h7F, 8'hE5, 8'hDF, 8'h6C};
    strobe(4'h4, 4'h2, 32'hAFFE7FE5, 32'h0000DF6C);
    chk("latency tx_valid after push edge", tx_valid, 1'b0);
    step();
    chk("latency tx_valid next edge", tx_valid, 1'b1);
    chk("latency marker", tx_data, 8'hA5);
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tx_valid) cnt++;
      else break;
    end
    chk("tx_valid cycle count", cnt, 8);
    cmp_stream("single stream");

    // Back-pressure: tx_ready toggles every cycle.
    filter_mask = 16'hFFFF;
    tx_ready    = 1'b0;
    push_frame(4'h4, 4'h1, 32'h89ABCDEF, 32'h0000003C);
    strobe(4'h4, 4'h1, 32'h89ABCDEF, 32'h0000003C);
    for (int i = 0; i < 40; i++) begin
      tx_ready = ~tx_ready;
      step();
    end
    tx_ready = 1'b1;
    wait_idle(40);
    cmp_stream("backpressure stream");

    // Overflow: 7 accepted strobes with the sink stalled.
    tx_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i < 5) push_frame(4'h2, 4'h1, 32'h10000000 + i, 32'(i));
      strobe(4'h2, 4'h1, 32'h10000000 + i, 32'(i));
    end
    step();
    chk("overflow count", overflow_count, 8'd2);
    chk("overflow busy", busy, 1'b1);
    chk("overflow marker waiting", tx_data, 8'hA5);
    tx_ready = 1'b1;
    wait_idle(100);
    cmp_stream("overflow frames");
    chk("overflow count after drain", overflow_count, 8'd2);

    // Saturation: far more drops than the counter can hold.
    tx_ready = 1'b0;
    for (int i = 0; i < 300; i++) strobe(4'h1, 4'h4, 32'(i), 32'(i));
    chk("overflow saturates", overflow_count, 8'hFF);

    // Plain reset clears the counter and the stalled stream.
    lpc_reset = 1'b1;
    step();
    chk("reset clears overflow", overflow_count, 8'h00);
    chk("reset clears busy", busy, 1'b0);
    lpc_reset = 1'b0;
    tx_ready  = 1'b0;
    step();

    // Reset during ADDR of the first frame with two records queued.
    strobe(4'h5, 4'h2, 32'hDEAD0001, 32'h1111);
    strobe(4'h5, 4'h2, 32'hDEAD0002, 32'h2222);
    strobe(4'h5, 4'h2, 32'hDEAD0003, 32'h3333);
    tx_ready = 1'b1;
    step();
    step();
    tx_ready = 1'b0;
    chk("reset-test in ADDR", tx_data, 8'hDE);
    #2;
    lpc_reset = 1'b1;
    #1;
    chk("async reset tx_valid", tx_valid, 1'b0);
    chk("async reset tx_data", tx_data, 8'h00);
    chk("async reset busy", busy, 1'b0);
    step();
    step();
    lpc_reset = 1'b0;
    got_q.delete();
    exp_q.delete();
    tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("post-reset silence", got_q.size(), 0);
    chk("post-reset busy", busy, 1'b0);
    push_frame(4'h6, 4'h4, 32'h0BADF00D, 32'hFEEDC0DE);
    strobe(4'h6, 4'h4, 32'h0BADF00D, 32'hFEEDC0DE);
    wait_idle(40);
    cmp_stream("post-reset frame");

    // Random traffic against the reference frame model, kept below overflow.
    for (int cyc = 0; cyc < 800; cyc++) begin
      while (ends.size() > 0 && ends[0] <= got_q.size()) void'(ends.pop_front());
      tx_ready = ($urandom_range(0, 9) < 7);
      if (ends.size() < DEPTH && $urandom_range(0, 2) == 0) begin
        r_ct = 4'($urandom_range(0, 15));
        r_sz = 4'($urandom_range(0, 4));
        r_ad = $urandom;
        r_da = $urandom;
        r_mk = 16'($urandom);
        filter_mask = r_mk;
        if (r_mk[r_ct]) begin
          push_frame(r_ct, r_sz, r_ad, r_da);
          ends.push_back(exp_q.size());
        end
        in_cyctype_dir = r_ct;
        in_data_size   = r_sz;
        in_addr        = r_ad;
        in_data        = r_da;
        in_valid       = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    in_valid = 1'b0;
    tx_ready = 1'b1;
    wait_idle(400);
    cmp_stream("random stream");
    chk("random overflow", overflow_count, 8'h00);
    chk("random busy end", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lpc_capture_sched.md
# lpc_capture_sched

Sequencer between the LPC cycle decoder and the byte-wide host link (UART transmitter). It accepts one decoded transaction per strobe and filters it by cycle type. Accepted transactions are queued in a small record FIFO. The block then serialises each record into a framed byte stream over a valid/ready handshake, and counts records lost to back-pressure.

## Interface
Parameters:
- DEPTH, 4: record FIFO entries; power of two, 2..16.

Ports:
- lpc_clock  in  1  sole clock; all state on rising edge.
- lpc_reset  in  1  reset; asynchronous, active-high.
- in_valid  in  1  one-cycle strobe from decoder (driven by its out_clock_enable).
- in_cyctype_dir  in  4  cycle type/direction nibble.
- in_addr  in  32  transaction address.
- in_data  in  32  transaction data, right-aligned.
- in_data_size  in  4  data bytes: 1, 2 or 4.
- filter_mask  in  16  bit i set = accept records with in_cyctype_dir == i.
- tx_data  out  8  current stream byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts byte on edge where tx_valid && tx_ready.
- overflow_count  out  8  dropped-record count, saturating.
- busy  out  1  FIFO non-empty or record in flight.

## Operation
- Accept: in_valid && filter_mask[in_cyctype_dir]. The record {ctdir, size, addr, data} (72 bits) is pushed if the FIFO is not full.
  - If the FIFO is full, it is pushed only when a pop occurs on the same edge.
  - Otherwise it is dropped and overflow_count increments, holding at 255.
- A filtered-out strobe changes nothing.
- Frame bytes, in order:
  - 8'hA5 marker.
  - Header {ctdir, size}.
  - addr[31:24], [23:16], [15:8], [7:0].
  - n data bytes, most significant first, taken from the low n bytes of data.
- n = size for size ∈ {1, 2, 4}; n = 0 for any other size. Frame length is 6+n bytes.
- FSM states: IDLE, MARK, HDR, ADDR (2-bit index 3→0), DATA (index n-1→0).
  - IDLE→MARK: FIFO non-empty. The head record is popped into the working register on that edge.
  - Advance to the next state/byte on each handshake.
  - After the last byte (ADDR idx 0 when n = 0, else DATA idx 0):
    - FIFO non-empty → MARK, popping the next head on the same edge.
    - FIFO empty → IDLE.
- tx_valid=1 in all states except IDLE. tx_data is registered and holds stable while tx_valid && !tx_ready.
- busy = (state≠IDLE) || FIFO non-empty.

## Timing
- Reset values:
  - tx_valid=0, tx_data=0, overflow_count=0, busy=0.
  - state=IDLE, FIFO empty (pointers 0).
- Reset mid-record: the in-flight record and all queued records are discarded, and tx_valid falls immediately (asynchronously).
- Latency: a record pushed at edge E into an empty FIFO while IDLE gives tx_valid=1 with tx_data=8'hA5 after edge E+1.
- Throughput: with tx_ready held high, one byte per cycle. No bubble between consecutive records.
- A push and a pop on the same edge leave the occupancy unchanged.
- The FIFO pointers are log2(DEPTH)+1 bits and wrap. full and empty are derived from the MSB comparison.
- Strobes arriving while a record is serialising are queued normally. The decoder's ≥ 1-cycle strobe spacing is not relied on.

## Structure
- Package lpc_capture_pkg holds:
  - the state enum;
  - the MARKER = 8'hA5 constant;
  - the REC_W = 72 constant;
  - the function data_bytes(size) returning n.
- Sub-module lpc_record_fifo (parameter DEPTH): synchronous push/pop, full/empty, registered head output, asynchronous active-high reset.
- The FSM, serialiser mux, filter and overflow counter live in lpc_capture_sched.

## Test plan
- Single record: ctdir=4, size=2, addr=32'hAFFE7FE5, data=32'h0000DF6C, mask bit 4 set, tx_ready=1.
  - Expected bytes: A5 42 AF FE 7F E5 DF 6C.
  - tx_valid is high for exactly 8 cycles.
  - tx_valid rises one edge after the push.
- Filter: the same record with mask bit 4 clear → no tx_valid, busy stays 0, overflow_count stays 0.
- Back-pressure: size=1, data=8'h3C, tx_ready toggling 1/0 → every byte is held stable until accepted. Stream is A5 41 addr×4 3C.
- Overflow: DEPTH=4, tx_ready=0, 7 accepted strobes.
  - 1 record in flight + 4 queued; overflow_count=2.
  - Release tx_ready → exactly 5 frames, in order.
- Illegal size: size=3 → 6-byte frame with header {ctdir, 4'h3} and no data bytes.
- Reset: assert lpc_reset during ADDR of the first frame with 2 records queued → tx_valid=0 at once. After release, no output until a new strobe arrives.
